// File: rtl/ddr3_sched_pkg.sv
// Shared types and default sizing for the DDR3 burst scheduler.
package ddr3_sched_pkg;

  localparam int DEF_ADDR_W      = 28;
  localparam int DEF_LEN_W       = 10;
  localparam int DEF_CNT_W       = 11;
  localparam int DEF_RFIFO_DEPTH = 1024;

  // The ping-pong bank bit takes the place of the top address bit.
  localparam int BANK_BIT_FROM_TOP = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARB     = 2'd1,
    ST_WR_WAIT = 2'd2,
    ST_RD_WAIT = 2'd3
  } sched_state_e;

endpackage

// File: rtl/ddr3_load_sync.sv
// Two-flop synchroniser plus rising-edge detector for a frame-start strobe
// arriving from a foreign clock domain.
module ddr3_load_sync (
  input  logic ui_clk,
  input  logic rst_n,
  input  logic load_async,
  output logic load_pulse
);

  logic meta_r;
  logic sync_r;
  logic sync_d_r;

  // Synchronise the strobe and keep one delayed copy for edge detection
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r   <= 1'b0;
      sync_r   <= 1'b0;
      sync_d_r <= 1'b0;
    end else begin
      meta_r   <= load_async;
      sync_r   <= meta_r;
      sync_d_r <= sync_r;
    end
  end

  // Both operands are flops, so the pulse is clean for one ui_clk cycle
  always_comb begin
    load_pulse = sync_r & ~sync_d_r;
  end

endmodule

// File: rtl/ddr3_burst_sched.sv
// Burst request scheduler between the pixel FIFO pair and the AXI burst
// master. Issues one write or read burst at a time, with wrapping address
// windows and optional two-bank ping-pong.
// Build option: DDR3_SCHED_ROUND_ROBIN_EN -- when defined, ties alternate
// between write and read; otherwise write has strict priority.
module ddr3_burst_sched
  import ddr3_sched_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int LEN_W       = DEF_LEN_W,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RFIFO_DEPTH = DEF_RFIFO_DEPTH
) (
  input  logic              ui_clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic [CNT_W-1:0]  wfifo_rcount,
  input  logic [CNT_W-1:0]  rfifo_wcount,
  input  logic [ADDR_W-1:0] addr_wr_min,
  input  logic [ADDR_W-1:0] addr_wr_max,
  input  logic [ADDR_W-1:0] addr_rd_min,
  input  logic [ADDR_W-1:0] addr_rd_max,
  input  logic [LEN_W-1:0]  wr_burst_len,
  input  logic [LEN_W-1:0]  rd_burst_len,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic              pingpang_en,
  input  logic              read_valid,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LEN_W-1:0]  wr_len,
  input  logic              wr_done,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [LEN_W-1:0]  rd_len,
  input  logic              rd_done,
  output logic              wr_bank,
  output logic              rd_bank
);

  localparam int BANK_POS = ADDR_W - BANK_BIT_FROM_TOP;
  localparam int SUM_W    = CNT_W + 1;
  localparam int PTR_W    = ADDR_W + 1;
  localparam logic [SUM_W-1:0] RFIFO_CAP = SUM_W'(RFIFO_DEPTH);

  sched_state_e state_r;
  sched_state_e state_nxt_s;

  logic              wr_load_s;
  logic              rd_load_s;
  logic              wr_elig_s;
  logic              rd_elig_s;
  logic              wr_elig_r;
  logic              rd_elig_r;
  logic [SUM_W-1:0]  rd_need_s;
  logic              pick_wr_s;
  logic              pick_rd_s;
  logic              issue_wr_s;
  logic              issue_rd_s;
  logic              wr_fin_s;
  logic              rd_fin_s;
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic              wr_pend_r;
  logic              rd_pend_r;
  logic [ADDR_W-1:0] wr_addr_nxt_s;
  logic [ADDR_W-1:0] rd_addr_nxt_s;
  logic [PTR_W-1:0]  wr_step_s;
  logic [PTR_W-1:0]  rd_step_s;
  logic [PTR_W-1:0]  wr_end_s;
  logic [PTR_W-1:0]  rd_end_s;
  logic              wr_wrap_s;
  logic              rd_wrap_s;

  ddr3_load_sync u_wr_load (
    .ui_clk     (ui_clk),
    .rst_n      (rst_n),
    .load_async (wr_load),
    .load_pulse (wr_load_s)
  );

  ddr3_load_sync u_rd_load (
    .ui_clk     (ui_clk),
    .rst_n      (rst_n),
    .load_async (rd_load),
    .load_pulse (rd_load_s)
  );

  // FIFO-level thresholds; the read sum is one bit wider so it cannot wrap
  always_comb begin
    rd_need_s = SUM_W'(rfifo_wcount) + SUM_W'(rd_burst_len);
    wr_elig_s = (wfifo_rcount >= CNT_W'(wr_burst_len));
    if (read_valid) begin
      rd_elig_s = (rd_need_s <= RFIFO_CAP);
    end else begin
      rd_elig_s = 1'b0;
    end
  end

  // Register eligibility so the arbiter sees a clean, one-cycle-old level
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_elig_r <= 1'b0;
      rd_elig_r <= 1'b0;
    end else begin
      wr_elig_r <= wr_elig_s;
      rd_elig_r <= rd_elig_s;
    end
  end

`ifdef DDR3_SCHED_ROUND_ROBIN_EN
  logic last_rd_r;

  // Remember which side was served last; starts as read so write goes first
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rd_r <= 1'b1;
    end else if (issue_wr_s) begin
      last_rd_r <= 1'b0;
    end else if (issue_rd_s) begin
      last_rd_r <= 1'b1;
    end
  end

  // On a tie the side not served last wins
  always_comb begin
    pick_wr_s = 1'b0;
    pick_rd_s = 1'b0;
    if (wr_elig_r && rd_elig_r) begin
      pick_wr_s = last_rd_r;
      pick_rd_s = ~last_rd_r;
    end else begin
      pick_wr_s = wr_elig_r;
      pick_rd_s = rd_elig_r;
    end
  end
`else
  // Write always wins a tie
  always_comb begin
    pick_wr_s = wr_elig_r;
    pick_rd_s = rd_elig_r & ~wr_elig_r;
  end
`endif

  // FSM state register
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: a burst in flight always completes before leaving
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (init_done) state_nxt_s = ST_ARB;
        else           state_nxt_s = ST_IDLE;
      end
      ST_ARB: begin
        if (!init_done)     state_nxt_s = ST_IDLE;
        else if (pick_wr_s) state_nxt_s = ST_WR_WAIT;
        else if (pick_rd_s) state_nxt_s = ST_RD_WAIT;
        else                state_nxt_s = ST_ARB;
      end
      ST_WR_WAIT: begin
        if (wr_done) state_nxt_s = init_done ? ST_ARB : ST_IDLE;
        else         state_nxt_s = ST_WR_WAIT;
      end
      ST_RD_WAIT: begin
        if (rd_done) state_nxt_s = init_done ? ST_ARB : ST_IDLE;
        else         state_nxt_s = ST_RD_WAIT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: issue strobes and done acceptance (dones outside a wait are dropped)
  always_comb begin
    issue_wr_s = 1'b0;
    issue_rd_s = 1'b0;
    wr_fin_s   = 1'b0;
    rd_fin_s   = 1'b0;
    case (state_r)
      ST_ARB: begin
        if (init_done) begin
          issue_wr_s = pick_wr_s;
          issue_rd_s = pick_rd_s;
        end else begin
          issue_wr_s = 1'b0;
          issue_rd_s = 1'b0;
        end
      end
      ST_WR_WAIT: wr_fin_s = wr_done;
      ST_RD_WAIT: rd_fin_s = rd_done;
      default: begin
        issue_wr_s = 1'b0;
        issue_rd_s = 1'b0;
      end
    endcase
  end

  // Start addresses with the bank bit substituted in ping-pong mode
  always_comb begin
    wr_addr_nxt_s = wr_ptr_r;
    rd_addr_nxt_s = rd_ptr_r;
    if (pingpang_en) begin
      wr_addr_nxt_s[BANK_POS] = wr_bank;
      rd_addr_nxt_s[BANK_POS] = rd_bank;
    end else begin
      wr_addr_nxt_s[BANK_POS] = wr_ptr_r[BANK_POS];
      rd_addr_nxt_s[BANK_POS] = rd_ptr_r[BANK_POS];
    end
  end

  // Pointer advance and wrap test: wrap when the following burst would overrun max
  always_comb begin
    wr_step_s = PTR_W'(wr_ptr_r) + PTR_W'(wr_len);
    wr_end_s  = wr_step_s + PTR_W'(wr_len);
    wr_wrap_s = (wr_end_s > PTR_W'(addr_wr_max));
    rd_step_s = PTR_W'(rd_ptr_r) + PTR_W'(rd_len);
    rd_end_s  = rd_step_s + PTR_W'(rd_len);
    rd_wrap_s = (rd_end_s > PTR_W'(addr_rd_max));
  end

  // Request pulses and burst descriptors, held until the next issue
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_req  <= 1'b0;
      rd_req  <= 1'b0;
      wr_addr <= {ADDR_W{1'b0}};
      rd_addr <= {ADDR_W{1'b0}};
      wr_len  <= {LEN_W{1'b0}};
      rd_len  <= {LEN_W{1'b0}};
    end else begin
      wr_req <= issue_wr_s;
      rd_req <= issue_rd_s;
      if (issue_wr_s) begin
        wr_addr <= wr_addr_nxt_s;
        wr_len  <= wr_burst_len;
      end
      if (issue_rd_s) begin
        rd_addr <= rd_addr_nxt_s;
        rd_len  <= rd_burst_len;
      end
    end
  end

  // Write pointer/bank; a frame-start during a burst is deferred to its done
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r  <= {ADDR_W{1'b0}};
      wr_pend_r <= 1'b0;
      wr_bank   <= 1'b0;
    end else if (state_r == ST_IDLE && init_done) begin
      wr_ptr_r  <= addr_wr_min;
      wr_pend_r <= 1'b0;
    end else if (wr_fin_s) begin
      if (wr_pend_r || wr_load_s) begin
        wr_ptr_r  <= addr_wr_min;
        wr_pend_r <= 1'b0;
      end else if (wr_wrap_s) begin
        wr_ptr_r <= addr_wr_min;
        wr_bank  <= pingpang_en ? ~wr_bank : 1'b0;
      end else begin
        wr_ptr_r <= wr_step_s[ADDR_W-1:0];
      end
    end else if (wr_load_s) begin
      if (state_r == ST_WR_WAIT || issue_wr_s) wr_pend_r <= 1'b1;
      else                                     wr_ptr_r  <= addr_wr_min;
    end
  end

  // Read pointer/bank; at a read wrap, read the frame the writer just finished
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r  <= {ADDR_W{1'b0}};
      rd_pend_r <= 1'b0;
      rd_bank   <= 1'b0;
    end else if (state_r == ST_IDLE && init_done) begin
      rd_ptr_r  <= addr_rd_min;
      rd_pend_r <= 1'b0;
    end else if (rd_fin_s) begin
      if (rd_pend_r || rd_load_s) begin
        rd_ptr_r  <= addr_rd_min;
        rd_pend_r <= 1'b0;
      end else if (rd_wrap_s) begin
        rd_ptr_r <= addr_rd_min;
        rd_bank  <= pingpang_en ? ~wr_bank : 1'b0;
      end else begin
        rd_ptr_r <= rd_step_s[ADDR_W-1:0];
      end
    end else if (rd_load_s) begin
      if (state_r == ST_RD_WAIT || issue_rd_s) rd_pend_r <= 1'b1;
      else                                     rd_ptr_r  <= addr_rd_min;
    end
  end

endmodule

// File: tb/tb_ddr3_burst_sched.sv
// Scoreboard bench for ddr3_burst_sched: expected requests are queued as
// stimulus is applied and matched when the scheduler issues them.
module tb_ddr3_burst_sched;

  localparam int AW = 28;
  localparam int LW = 10;
  localparam int CW = 11;

  logic          ui_clk = 1'b0;
  logic          rst_n;
  logic          init_done;
  logic [CW-1:0] wfifo_rcount;
  logic [CW-1:0] rfifo_wcount;
  logic [AW-1:0] addr_wr_min, addr_wr_max, addr_rd_min, addr_rd_max;
  logic [LW-1:0] wr_burst_len, rd_burst_len;
  logic          wr_load, rd_load, pingpang_en, read_valid;
  logic          wr_req, rd_req, wr_done, rd_done, wr_bank, rd_bank;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [LW-1:0] wr_len, rd_len;

  ddr3_burst_sched dut (
    .ui_clk       (ui_clk),
    .rst_n        (rst_n),
    .init_done    (init_done),
    .wfifo_rcount (wfifo_rcount),
    .rfifo_wcount (rfifo_wcount),
    .addr_wr_min  (addr_wr_min),
    .addr_wr_max  (addr_wr_max),
    .addr_rd_min  (addr_rd_min),
    .addr_rd_max  (addr_rd_max),
    .wr_burst_len (wr_burst_len),
    .rd_burst_len (rd_burst_len),
    .wr_load      (wr_load),
    .rd_load      (rd_load),
    .pingpang_en  (pingpang_en),
    .read_valid   (read_valid),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_len       (wr_len),
    .wr_done      (wr_done),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_len       (rd_len),
    .rd_done      (rd_done),
    .wr_bank      (wr_bank),
    .rd_bank      (rd_bank)
  );

  always #5 ui_clk = ~ui_clk;

  typedef struct {
    bit            is_wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total_cnt = 0;
  int   bad_cnt   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input bit is_wr, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    exp_t e;
    e.is_wr = is_wr;
    e.addr  = addr;
    e.len   = len;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every request pulse must match the oldest queued expectation
  always @(negedge ui_clk) begin
    if (wr_req === 1'b1 || rd_req === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_req", {30'd0, wr_req, rd_req}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_val("req_kind", {30'd0, wr_req, rd_req}, mon_e.is_wr ? 32'd2 : 32'd1);
        if (mon_e.is_wr) begin
          check_val("wr_addr", wr_addr, mon_e.addr);
          check_val("wr_len", wr_len, mon_e.len);
        end else begin
          check_val("rd_addr", rd_addr, mon_e.addr);
          check_val("rd_len", rd_len, mon_e.len);
        end
      end
    end
  end

  task automatic wait_req(output bit is_wr);
    int n;
    n = 0;
    do begin
      @(negedge ui_clk);
      n++;
    end while (!(wr_req === 1'b1 || rd_req === 1'b1) && n < 300);
    if (!(wr_req === 1'b1 || rd_req === 1'b1)) check_val("req_timeout", 32'd0, 32'd1);
    is_wr = (wr_req === 1'b1);
  endtask

  task automatic pulse_done(input bit is_wr);
    @(posedge ui_clk); #1;
    if (is_wr) wr_done = 1'b1;
    else       rd_done = 1'b1;
    @(posedge ui_clk); #1;
    wr_done = 1'b0;
    rd_done = 1'b0;
  endtask

  task automatic pulse_load(input bit is_wr);
    @(posedge ui_clk); #1;
    if (is_wr) wr_load = 1'b1;
    else       rd_load = 1'b1;
    repeat (3) @(posedge ui_clk);
    #1;
    wr_load = 1'b0;
    rd_load = 1'b0;
    repeat (6) @(posedge ui_clk);
    #1;
  endtask

  task automatic check_outs_zero(input string tag);
    check_val({tag, "_wr_req"},  wr_req,  32'd0);
    check_val({tag, "_rd_req"},  rd_req,  32'd0);
    check_val({tag, "_wr_addr"}, wr_addr, 32'd0);
    check_val({tag, "_rd_addr"}, rd_addr, 32'd0);
    check_val({tag, "_wr_len"},  wr_len,  32'd0);
    check_val({tag, "_rd_len"},  rd_len,  32'd0);
    check_val({tag, "_wr_bank"}, wr_bank, 32'd0);
    check_val({tag, "_rd_bank"}, rd_bank, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit w;
    rst_n = 1'b0; init_done = 1'b0;
    wfifo_rcount = 11'd0; rfifo_wcount = 11'd0;
    addr_wr_min = 28'h100; addr_wr_max = 28'h800;
    addr_rd_min = 28'h1000; addr_rd_max = 28'h1200;
    wr_burst_len = 10'd128; rd_burst_len = 10'd128;
    wr_load = 1'b0; rd_load = 1'b0; pingpang_en = 1'b1; read_valid = 1'b0;
    wr_done = 1'b0; rd_done = 1'b0;
    repeat (3) @(posedge ui_clk);
    #1;
    check_outs_zero("reset");

    // Calibration not done: nothing may issue
    rst_n = 1'b1; wfifo_rcount = 11'd256;
    repeat (50) @(posedge ui_clk);
    #1;
    check_outs_zero("no_init");

    // First request comes from the write window min
    push_exp(1'b1, 28'h100, 10'd128);
    init_done = 1'b1;
    wait_req(w);
    wfifo_rcount = 11'd0;
    repeat (3) @(posedge ui_clk);
    #1;
    check_val("wr_addr_hold", wr_addr, 28'h100);
    pulse_done(1'b1);
    check_val("wr_addr_after_done", wr_addr, 28'h100);

    // Write window 0..0x400, bursts of 0x100, wrap toggles the bank
    addr_wr_min = 28'h0; addr_wr_max = 28'h400; wr_burst_len = 10'h100;
    pulse_load(1'b1);
    push_exp(1'b1, 28'h000, 10'h100);
    push_exp(1'b1, 28'h100, 10'h100);
    push_exp(1'b1, 28'h200, 10'h100);
    push_exp(1'b1, 28'h300, 10'h100);
    push_exp(1'b1, 28'h8000000, 10'h100);
    wfifo_rcount = 11'h100;
    for (int i = 0; i < 5; i++) begin
      wait_req(w);
      if (i == 4) wfifo_rcount = 11'd0;
      pulse_done(1'b1);
      if (i == 2) check_val("wr_bank_before_wrap", wr_bank, 32'd0);
      if (i == 3) check_val("wr_bank_after_wrap", wr_bank, 32'd1);
    end
    check_val("rd_bank_untouched", rd_bank, 32'd0);

    // Frame-start while a write is in flight: address held, next burst from min
    push_exp(1'b1, 28'h8000100, 10'h100);
    push_exp(1'b1, 28'h8000000, 10'h100);
    wfifo_rcount = 11'h100;
    wait_req(w);
    pulse_load(1'b1);
    check_val("wr_addr_load_hold", wr_addr, 28'h8000100);
    pulse_done(1'b1);
    check_val("wr_addr_post_done", wr_addr, 28'h8000100);
    wait_req(w);
    wfifo_rcount = 11'd0;
    pulse_done(1'b1);
    check_val("wr_bank_after_load", wr_bank, 32'd1);

    // Stray dones outside a wait state must be ignored
    pulse_done(1'b1);
    pulse_done(1'b0);

    // Read FIFO room boundary and 2-cycle request latency
    rfifo_wcount = 11'd960; read_valid = 1'b1;
    repeat (20) @(posedge ui_clk);
    #1;
    check_val("rd_blocked", rd_req, 32'd0);
    push_exp(1'b0, 28'h1000, 10'd128);
    rfifo_wcount = 11'd896;
    @(posedge ui_clk); #1;
    check_val("rd_lat_cycle1", rd_req, 32'd0);
    @(posedge ui_clk); #1;
    check_val("rd_lat_cycle2", rd_req, 32'd1);
    rfifo_wcount = 11'd0;
    push_exp(1'b0, 28'h1080, 10'd128);
    push_exp(1'b0, 28'h1100, 10'd128);
    push_exp(1'b0, 28'h1180, 10'd128);
    push_exp(1'b0, 28'h1000, 10'd128);
    pulse_done(1'b0);
    for (int i = 0; i < 4; i++) begin
      wait_req(w);
      if (i == 3) read_valid = 1'b0;
      pulse_done(1'b0);
    end
    check_val("rd_bank_follows_wr", rd_bank, 32'd0);

    // Both sides eligible: arbitration order
`ifdef DDR3_SCHED_ROUND_ROBIN_EN
    push_exp(1'b1, 28'h8000100, 10'h100);
    push_exp(1'b0, 28'h1080, 10'd128);
    push_exp(1'b1, 28'h8000200, 10'h100);
    push_exp(1'b0, 28'h1100, 10'd128);
`else
    push_exp(1'b1, 28'h8000100, 10'h100);
    push_exp(1'b1, 28'h8000200, 10'h100);
    push_exp(1'b1, 28'h8000300, 10'h100);
    push_exp(1'b1, 28'h0000000, 10'h100);
`endif
    wfifo_rcount = 11'h100; rfifo_wcount = 11'd0; read_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_req(w);
      if (i == 3) begin
        wfifo_rcount = 11'd0;
        read_valid = 1'b0;
      end
      pulse_done(w);
    end

    // Reset during a read burst clears outputs immediately
    read_valid = 1'b1;
`ifdef DDR3_SCHED_ROUND_ROBIN_EN
    push_exp(1'b0, 28'h1180, 10'd128);
`else
    push_exp(1'b0, 28'h1080, 10'd128);
`endif
    wait_req(w);
    @(posedge ui_clk); #1;
    rst_n = 1'b0;
    #1;
    check_outs_zero("rst_in_rd_wait");
    repeat (3) @(posedge ui_clk);
    #1;
    pingpang_en = 1'b0;
    push_exp(1'b0, 28'h1000, 10'd128);
    rst_n = 1'b1;
    wait_req(w);
    read_valid = 1'b0;
    pulse_done(1'b0);

    // Without ping-pong the wrap leaves the bank at 0
    push_exp(1'b1, 28'h000, 10'h100);
    push_exp(1'b1, 28'h100, 10'h100);
    push_exp(1'b1, 28'h200, 10'h100);
    push_exp(1'b1, 28'h300, 10'h100);
    push_exp(1'b1, 28'h000, 10'h100);
    wfifo_rcount = 11'h100;
    for (int i = 0; i < 5; i++) begin
      wait_req(w);
      if (i == 4) wfifo_rcount = 11'd0;
      pulse_done(1'b1);
    end
    check_val("wr_bank_no_pp", wr_bank, 32'd0);

    repeat (5) @(posedge ui_clk);
    #1;
    check_val("scoreboard_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/ddr3_burst_sched.md
# ddr3_burst_sched

Burst request scheduler between the pixel FIFO pair and the AXI burst master in the DDR3 frame-buffer path. It runs in the `ui_clk` domain and watches the write-FIFO read level and the read-FIFO write level. It issues one write or read burst request at a time, each with a start address and a length. It keeps write and read address pointers that wrap inside configurable windows, with optional ping-pong between two frame banks.

## Interface
Parameters:
- `ADDR_W`, 28: word-address width.
- `LEN_W`, 10: burst-length width.
- `CNT_W`, 11: FIFO level width.
- `RFIFO_DEPTH`, 1024: read-FIFO capacity in 128-bit words.

Ports:
- `ui_clk` in 1: controller user clock. All logic is synchronous to it.
- `rst_n` in 1: reset, asynchronous, active-low.
- `init_done` in 1: DDR3 calibration complete (level).
- `wfifo_rcount` in CNT_W: words available in the write FIFO.
- `rfifo_wcount` in CNT_W: words occupied in the read FIFO.
- `addr_wr_min`, `addr_wr_max` in ADDR_W: write window, max exclusive.
- `addr_rd_min`, `addr_rd_max` in ADDR_W: read window, max exclusive.
- `wr_burst_len`, `rd_burst_len` in LEN_W: words per burst, nonzero.
- `wr_load`, `rd_load` in 1: frame-start strobes from foreign clock domains.
- `pingpang_en` in 1: two-bank mode, static.
- `read_valid` in 1: reads permitted (level).
- `wr_req` out 1: write burst request pulse.
- `wr_addr` out ADDR_W: write burst start address.
- `wr_len` out LEN_W: write burst length.
- `wr_done` in 1: write burst finished pulse.
- `rd_req` out 1: read burst request pulse.
- `rd_addr` out ADDR_W: read burst start address.
- `rd_len` out LEN_W: read burst length.
- `rd_done` in 1: read burst finished pulse.
- `wr_bank`, `rd_bank` out 1: current bank bits.

## Operation
- States:
  - IDLE: stays here until `init_done` goes high.
  - ARB: chooses the next burst.
  - WR_WAIT: waits for `wr_done`.
  - RD_WAIT: waits for `rd_done`.
- Eligibility:
  - Write is eligible when `wfifo_rcount >= wr_burst_len`.
  - Read is eligible when `read_valid` and `rfifo_wcount + rd_burst_len <= RFIFO_DEPTH`. The sum is computed CNT_W+1 wide.
- In ARB:
  - If write is eligible (subject to the arbitration policy): latch `wr_addr` = current write pointer with the bank bit applied and `wr_len` = `wr_burst_len`, pulse `wr_req`, go to WR_WAIT.
  - Else if read is eligible: do the same on the read side, go to RD_WAIT.
  - Else stay in ARB.
- On `wr_done`:
  - `ptr += wr_len`.
  - If `ptr + wr_len > addr_wr_max`, set `ptr = addr_wr_min` and toggle `wr_bank` when `pingpang_en`.
  - Return to ARB.
- On `rd_done`: the read pointer follows the same rule using the read window.
- Read bank selection: at each read-window wrap, `rd_bank` is set to `~wr_bank` (the last completed frame). Without `pingpang_en`, both bank bits are held at 0.
- Bank bit: when `pingpang_en`, it replaces address bit ADDR_W-1.
- Frame-start strobes: `wr_load` and `rd_load` are synchronised (2 flops) and rising-edge detected.
  - A detected strobe resets its pointer to the window min.
  - If that side's burst is in flight, the reset is deferred until the matching done, and the normal increment for that burst is skipped.
- `wr_done` or `rd_done` arriving in the wrong state is ignored.

## Timing
- Reset values:
  - State is IDLE.
  - `wr_req`, `rd_req` = 0.
  - `wr_addr` = 0, `rd_addr` = 0, `wr_len` = 0, `rd_len` = 0.
  - `wr_bank` = 0, `rd_bank` = 0.
  - Pointers are loaded from the window min on the first ARB entry.
- Requests are one-cycle registered pulses. `*_addr` and `*_len` stay stable from the request cycle until the cycle after the matching done.
- From a FIFO level crossing the threshold to the request pulse: 2 cycles (registered eligibility, then the ARB decision).
- After a done, the next request can issue 2 cycles later, at the earliest.
- At most one outstanding burst at any time.
- Loss of `init_done` returns the block to IDLE only after the in-flight done arrives.
- Load-strobe latency: 3 `ui_clk` cycles, plus the strobe's source-clock width. Strobes must be at least 2 `ui_clk` periods wide.

## Configuration
- Macro `DDR3_SCHED_ROUND_ROBIN_EN`:
  - Defined: when both sides are eligible in ARB, the side not served last wins. The last-served flag resets to "read".
  - Undefined: write always has strict priority over read.

## Structure
- Package `ddr3_sched_pkg` holds:
  - the state enum (IDLE/ARB/WR_WAIT/RD_WAIT);
  - the default widths ADDR_W, LEN_W, CNT_W and RFIFO_DEPTH;
  - the bank-bit position constant.
- Sub-module `ddr3_load_sync`: 2-flop synchroniser plus rising-edge detector. One instance for `wr_load`, one for `rd_load`.

## Test plan
- Reset release, `init_done` held at 0 for 50 cycles → no requests, all outputs 0. `init_done` then rises with `wfifo_rcount`=256, `wr_burst_len`=128 → `wr_req` pulses with `wr_addr`=`addr_wr_min`, `wr_len`=128.
- Write window 0x000–0x400, len 0x100, four bursts with dones → addresses 0x000, 0x100, 0x200, 0x300, then 0x000. With `pingpang_en`, `wr_bank` toggles to 1 after the fourth done.
- Both sides eligible continuously with `DDR3_SCHED_ROUND_ROBIN_EN` defined → requests alternate W,R,W,R. With the macro undefined → W only.
- `rfifo_wcount`=960, `rd_burst_len`=128, `RFIFO_DEPTH`=1024 → no `rd_req`. Drop `rfifo_wcount` to 896 → `rd_req` 2 cycles later.
- `wr_load` during WR_WAIT → `wr_addr` is unchanged until `wr_done`. The next `wr_addr` is `addr_wr_min`, not the incremented pointer.
- `rst_n` asserted in RD_WAIT → all outputs 0 immediately. After release, the first request comes from the window min.
